irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
Machine-mode interrupt scheduler between the ACLINT/external interrupt sources and the CSR/trap unit.
- Synchronizes the external interrupt line and builds the mip view.
- Arbitrates enabled pending interrupts by fixed priority.
- Presents one interrupt at a time to the trap unit on an instruction boundary, with a req/ack handshake and a post-ack holdoff.

Parameters:
XLEN, 64, width of cause and mip read data.
SYNC_STAGES, 2, flop stages on meip_async (legal values 2 or 3).
HOLDOFF_CYCLES, 2, cycles after ack before a new request may arm (legal range 1-15).

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous and active-high (fixed).
meip_async  in  1  external interrupt, asynchronous to clk.
mtip  in  1  timer interrupt from ACLINT, synchronous to clk.
msip  in  1  software interrupt from ACLINT, synchronous to clk.
mstatus_mie  in  1  global machine interrupt enable.
mie  in  XLEN  mie CSR value; only bits 11, 7 and 3 are used.
commit_valid  in  1  an instruction retires this cycle (instruction boundary).
trap_busy  in  1  the trap unit is taking an exception or mret this cycle.
irq_ack  in  1  the trap unit has accepted the current request.
irq_req  out  1  interrupt request to the trap unit.
irq_cause  out  XLEN  mcause value for the request.
mip_rdata  out  XLEN  mip read value.

Behaviour:
- Reset (async assert, sync release): state=IDLE; irq_req=0; irq_cause=0; sync flops=0; holdoff counter=0; mip_rdata=0.
- Asserting rst mid-request drops irq_req immediately, with no ack needed.
- Synchronizer: meip_async passes through SYNC_STAGES flops and becomes meip_s.
- mip_rdata: bit 11 = meip_s, bit 7 = mtip, bit 3 = msip, all other bits 0. Read-only; combinational from flops and inputs.
- pend[i] = mip bit i AND mie bit i. Interrupts are eligible only when mstatus_mie=1 and any pend bit is set.
- Priority is fixed: MEI (code 11) > MSI (code 3) > MTI (code 7).
- Cause encoding: bit XLEN-1 = 1; low bits = code; all other bits 0.
- State machine, evaluated each cycle:
  - IDLE: if eligible, go to ARM.
  - ARM:
    - If not eligible, go to IDLE.
    - Else if commit_valid=1 and trap_busy=0: latch the winning cause into irq_cause, set irq_req=1, go to REQ.
    - commit_valid=1 with trap_busy=1 stays in ARM; exceptions win over interrupts.
  - REQ:
    - irq_req and irq_cause are held stable.
    - If irq_ack=1: irq_req=0; load holdoff counter with HOLDOFF_CYCLES; go to HOLD.
    - Else if the latched source's pend bit drops, or mstatus_mie drops: irq_req=0; go to IDLE (withdrawal).
    - irq_ack and withdrawal in the same cycle: ack wins.
    - A higher-priority source arriving while in REQ does not replace the latched cause.
  - HOLD:
    - Counter decrements each cycle.
    - When the counter reaches 1, go to IDLE.
    - Pending sources are ignored while in HOLD; the trap unit clears mstatus_mie during this window.
- irq_ack outside REQ is ignored.
- Latency:
  - meip_async rising to meip_s: SYNC_STAGES cycles.
  - An eligible source in IDLE enters ARM on the next edge.
  - irq_req asserts at the edge following the first ARM cycle with commit_valid=1 and trap_busy=0.
  - Minimum source-to-irq_req latency for mtip/msip is 2 cycles.
- irq_cause keeps its last value after the request ends. It is meaningful only while irq_req=1.

Decomposition:
- Shared package (alongside the existing CSR address and exception-cause definitions):
  - interrupt code constants: MACHINE_SOFTWARE_INTERRUPT=3, MACHINE_TIMER_INTERRUPT=7, MACHINE_EXTERNAL_INTERRUPT=11;
  - MIP/MIE bit-position constants;
  - an IrqState enum {IDLE, ARM, REQ, HOLD}.
- One sub-module is natural: sync_ff, a parameterized N-stage 1-bit synchronizer with async active-high reset. It is instantiated for meip_async.

Test Plan:
1. Reset: rst=1 with all sources high and enables on -> irq_req=0, irq_cause=0, mip_rdata=0. After release with commit_valid=1 every cycle: irq_req=1 with irq_cause=0x8000_0000_0000_000B (meip after 2-stage sync).
2. Priority: mtip=1, msip=1, mie bits 7 and 3 set, mstatus_mie=1, commit_valid=1 -> irq_cause=0x8000_0000_0000_0003. Ack, then hold msip=0 -> after 2 holdoff cycles a new request with cause 0x8000_0000_0000_0007.
3. Boundary gating: mtip eligible, commit_valid=0 for 5 cycles -> irq_req=0. Then commit_valid=1 with trap_busy=1 -> irq_req stays 0. The next cycle commit_valid=1, trap_busy=0 -> irq_req=1 at the next edge.
4. Withdrawal: in REQ with mtip cause, drop mtip with irq_ack=0 -> irq_req=0 next cycle, state IDLE. Repeat with the drop and irq_ack=1 in the same cycle -> ack taken, state HOLD.
5. Masking: mstatus_mie=0 with all pend bits set -> irq_req never asserts, while mip_rdata=0x888.
6. Async reset mid-REQ: pulse rst for half a cycle while irq_req=1 -> irq_req=0 without a clock edge; no request for SYNC_STAGES cycles after release when only meip is set.

Source files
------------

// File: rtl/irq_sequencer_pkg.sv
// Shared machine-mode interrupt definitions: cause codes, mip/mie bit
// positions and the sequencer state encoding.
package irq_sequencer_pkg;

    localparam int MACHINE_SOFTWARE_INTERRUPT = 3;
    localparam int MACHINE_TIMER_INTERRUPT    = 7;
    localparam int MACHINE_EXTERNAL_INTERRUPT = 11;

    localparam int MIP_MSIP_BIT = 3;
    localparam int MIP_MTIP_BIT = 7;
    localparam int MIP_MEIP_BIT = 11;
    localparam int MIE_MSIE_BIT = 3;
    localparam int MIE_MTIE_BIT = 7;
    localparam int MIE_MEIE_BIT = 11;

    typedef enum logic [1:0] {IDLE, ARM, REQ, HOLD} IrqState;

    // Fixed priority MEI > MSI > MTI; caller guarantees at least one bit set.
    function automatic logic [3:0] irq_winner(input logic ext, input logic sw);
        if (ext)     return 4'(MACHINE_EXTERNAL_INTERRUPT);
        else if (sw) return 4'(MACHINE_SOFTWARE_INTERRUPT);
        else         return 4'(MACHINE_TIMER_INTERRUPT);
    endfunction

endpackage

// File: rtl/irq_sequencer_sync_ff.sv
// N-stage single-bit synchronizer with asynchronous active-high reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/irq_sequencer.sv
// Machine-mode interrupt sequencer: builds mip, arbitrates enabled pending
// sources and hands one request at a time to the trap unit on a retire boundary.
module irq_sequencer
    import irq_sequencer_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            meip_async,
    input  logic            mtip,
    input  logic            msip,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] mie,
    input  logic            commit_valid,
    input  logic            trap_busy,
    input  logic            irq_ack,
    output logic            irq_req,
    output logic [XLEN-1:0] irq_cause,
    output logic [XLEN-1:0] mip_rdata
);

    logic meip_s;
    logic pend_ext, pend_sw, pend_tmr, eligible, latched_pend;
    logic [3:0] win_code;

    IrqState         state_q, state_d;
    logic            irq_req_q, irq_req_d;
    logic [XLEN-1:0] irq_cause_q, irq_cause_d;
    logic [3:0]      hold_cnt_q, hold_cnt_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_meip_sync (
        .clk (clk),
        .rst (rst),
        .d_i (meip_async),
        .q_o (meip_s)
    );

    // mtip/msip are raw inputs, so mask them while reset is held.
    always_comb begin
        mip_rdata = '0;
        if (!rst) begin
            mip_rdata[MIP_MEIP_BIT] = meip_s;
            mip_rdata[MIP_MTIP_BIT] = mtip;
            mip_rdata[MIP_MSIP_BIT] = msip;
        end
    end

    assign pend_ext = meip_s & mie[MIE_MEIE_BIT];
    assign pend_sw  = msip   & mie[MIE_MSIE_BIT];
    assign pend_tmr = mtip   & mie[MIE_MTIE_BIT];
    assign eligible = mstatus_mie & (pend_ext | pend_sw | pend_tmr);
    assign win_code = irq_winner(pend_ext, pend_sw);

    logic unused_mie;
    assign unused_mie = ^{mie[XLEN-1:12], mie[10:8], mie[6:4], mie[2:0]};

    always_comb begin
        case (irq_cause_q[3:0])
            4'(MACHINE_EXTERNAL_INTERRUPT): latched_pend = pend_ext;
            4'(MACHINE_SOFTWARE_INTERRUPT): latched_pend = pend_sw;
            default:                        latched_pend = pend_tmr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            irq_req_q   <= 1'b0;
            irq_cause_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            irq_req_q   <= irq_req_d;
            irq_cause_q <= irq_cause_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        irq_req_d   = irq_req_q;
        irq_cause_d = irq_cause_q;
        hold_cnt_d  = hold_cnt_q;
        case (state_q)
            IDLE: if (eligible) state_d = ARM;
            ARM: begin
                if (!eligible) begin
                    state_d = IDLE;
                end else if (commit_valid && !trap_busy) begin
                    irq_cause_d = {1'b1, {(XLEN-5){1'b0}}, win_code};
                    irq_req_d   = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // Ack takes priority over a simultaneous withdrawal.
                if (irq_ack) begin
                    irq_req_d  = 1'b0;
                    hold_cnt_d = 4'(HOLDOFF_CYCLES);
                    state_d    = HOLD;
                end else if (!latched_pend || !mstatus_mie) begin
                    irq_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            HOLD: begin
                hold_cnt_d = hold_cnt_q - 4'd1;
                if (hold_cnt_q <= 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign irq_req   = irq_req_q;
    assign irq_cause = irq_cause_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: reset, priority, boundary gating,
// withdrawal, masking and asynchronous reset during a request.
module tb_irq_sequencer;
    import irq_sequencer_pkg::*;

    localparam logic [63:0] CAUSE_MEI = 64'h8000_0000_0000_000B;
    localparam logic [63:0] CAUSE_MSI = 64'h8000_0000_0000_0003;
    localparam logic [63:0] CAUSE_MTI = 64'h8000_0000_0000_0007;

    logic        clk = 1'b0;
    logic        rst, meip_async, mtip, msip, mstatus_mie;
    logic [63:0] mie;
    logic        commit_valid, trap_busy, irq_ack;
    logic        irq_req;
    logic [63:0] irq_cause, mip_rdata;

    int tests  = 0;
    int failed = 0;

    irq_sequencer #(.XLEN(64), .SYNC_STAGES(2), .HOLDOFF_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .meip_async   (meip_async),
        .mtip         (mtip),
        .msip         (msip),
        .mstatus_mie  (mstatus_mie),
        .mie          (mie),
        .commit_valid (commit_valid),
        .trap_busy    (trap_busy),
        .irq_ack      (irq_ack),
        .irq_req      (irq_req),
        .irq_cause    (irq_cause),
        .mip_rdata    (mip_rdata)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input IrqState exp);
        chk(tag, 64'(dut.state_q), 64'(exp));
    endtask

    initial begin
        rst = 1'b1; meip_async = 1'b1; mtip = 1'b1; msip = 1'b1;
        mstatus_mie = 1'b1; mie = '1; commit_valid = 1'b1;
        trap_busy = 1'b0; irq_ack = 1'b0;

        // 1. reset with everything asserted, then meip alone after release
        step(2);
        chk("rst_req", 64'(irq_req), 64'd0);
        chk("rst_cause", irq_cause, 64'd0);
        chk("rst_mip", mip_rdata, 64'd0);
        mtip = 1'b0; msip = 1'b0;
        step(1);
        rst = 1'b0;
        step(1);
        chk("sync1_mip", mip_rdata, 64'd0);
        step(1);
        chk("sync2_mip", mip_rdata, 64'h800);
        chk("sync2_req", 64'(irq_req), 64'd0);
        step(1);
        chk("arm_req", 64'(irq_req), 64'd0);
        step(1);
        chk("mei_req", 64'(irq_req), 64'd1);
        chk("mei_cause", irq_cause, CAUSE_MEI);
        irq_ack = 1'b1; meip_async = 1'b0;
        step(1);
        irq_ack = 1'b0;
        chk("mei_ack_req", 64'(irq_req), 64'd0);
        step(2);
        chk_state("mei_hold_done", IDLE);

        // 2. priority MSI over MTI, then MTI after holdoff
        mtip = 1'b1; msip = 1'b1;
        step(2);
        chk("prio_req", 64'(irq_req), 64'd1);
        chk("prio_cause", irq_cause, CAUSE_MSI);
        irq_ack = 1'b1; msip = 1'b0;
        step(1);
        irq_ack = 1'b0;
        chk_state("prio_hold", HOLD);
        step(1);
        chk("hold1_req", 64'(irq_req), 64'd0);
        step(2);
        chk("hold_arm_req", 64'(irq_req), 64'd0);
        step(1);
        chk("mti_req", 64'(irq_req), 64'd1);
        chk("mti_cause", irq_cause, CAUSE_MTI);

        // 4. withdrawal, then ack coinciding with withdrawal
        mtip = 1'b0;
        step(1);
        chk("wd_req", 64'(irq_req), 64'd0);
        chk_state("wd_state", IDLE);
        mtip = 1'b1;
        step(2);
        chk("wd2_req", 64'(irq_req), 64'd1);
        mtip = 1'b0; irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        chk("ackwd_req", 64'(irq_req), 64'd0);
        chk_state("ackwd_state", HOLD);
        step(2);

        // 3. instruction-boundary gating and trap_busy
        commit_valid = 1'b0; mtip = 1'b1;
        step(5);
        chk("nocommit_req", 64'(irq_req), 64'd0);
        chk_state("nocommit_state", ARM);
        commit_valid = 1'b1; trap_busy = 1'b1;
        step(1);
        chk("busy_req", 64'(irq_req), 64'd0);
        trap_busy = 1'b0;
        step(1);
        chk("gate_req", 64'(irq_req), 64'd1);
        chk("gate_cause", irq_cause, CAUSE_MTI);
        msip = 1'b1;
        step(1);
        chk("noreplace_cause", irq_cause, CAUSE_MTI);
        irq_ack = 1'b1; mtip = 1'b0; msip = 1'b0;
        step(1);
        irq_ack = 1'b0;
        step(2);
        chk("gate_after_cause", irq_cause, CAUSE_MTI);

        // 5. global mask: nothing requested, mip still visible, stray ack ignored
        mstatus_mie = 1'b0; mtip = 1'b1; msip = 1'b1; meip_async = 1'b1;
        step(3);
        chk("mask_mip", mip_rdata, 64'h888);
        irq_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("mask_req", 64'(irq_req), 64'd0);
        end
        irq_ack = 1'b0;
        chk_state("mask_state", IDLE);
        meip_async = 1'b0; msip = 1'b0;
        step(2);

        // 6. async reset in the middle of a request
        mstatus_mie = 1'b1;
        step(2);
        chk("pre_rst_req", 64'(irq_req), 64'd1);
        chk("pre_rst_cause", irq_cause, CAUSE_MTI);
        rst = 1'b1;
        #1;
        chk("async_rst_req", 64'(irq_req), 64'd0);
        chk("async_rst_cause", irq_cause, 64'd0);
        mtip = 1'b0; meip_async = 1'b1;
        #2;
        rst = 1'b0;
        step(1);
        chk("post_rst1_req", 64'(irq_req), 64'd0);
        step(1);
        chk("post_rst2_req", 64'(irq_req), 64'd0);
        step(2);
        chk("post_rst_mei_req", 64'(irq_req), 64'd1);
        chk("post_rst_mei_cause", irq_cause, CAUSE_MEI);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
